uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
- Consumes the byte stream coming out of the UART receiver (AXI-Stream, 8-bit, no tlast).
- Hunts for framed commands of the form 0xAA 0x55 CMD LEN PAYLOAD[LEN] SUM, verifies length and checksum, and buffers the payload.
- Only checksum-clean frames are released downstream: a one-cycle command strobe, then the payload as an AXI-Stream packet with tlast.
- Sits between the UART RX stage and the command/register logic of the NFC/HR design.

Parameters:
- MAX_LEN, 32, largest accepted payload length in bytes (1..255); sets payload buffer depth.
- TIMEOUT_CYCLES, 50000, maximum clk cycles allowed between two bytes inside a frame before the frame is abandoned.
- HDR0, 8'hAA, first header byte.
- HDR1, 8'h55, second header byte.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_tvalid  input  1  input byte valid (from UART RX).
- i_tready  output  1  parser accepts input byte.
- i_tdata  input  8  input byte.
- o_cmd_valid  output  1  one-cycle strobe: a verified frame is available.
- o_cmd  output  8  CMD of the current frame; stable from o_cmd_valid until the last payload beat is accepted.
- o_len  output  8  LEN of the current frame; same stability as o_cmd.
- o_tvalid  output  1  payload beat valid.
- o_tready  input  1  downstream accepts payload beat.
- o_tdata  output  8  payload byte.
- o_tlast  output  1  marks the final payload beat.
- o_err_sum  output  16  checksum-error count (STAT feature).
- o_err_len  output  16  length-error count (STAT feature).
- o_err_tmo  output  16  timeout count (STAT feature).

Behaviour:
- Interface decisions: one clock; reset is asynchronous and active-high. Clock port is clk; reset port is rst.
- Reset values:
  - FSM returns to S_HDR0; byte-gap timer and checksum accumulator clear.
  - i_tready=1; o_cmd_valid=0; o_tvalid=0; o_tlast=0; o_tdata=0; o_cmd=0; o_len=0; all counters=0.
  - A reset mid-frame or mid-output discards everything; no partial output afterwards.
- Byte acceptance: a byte is consumed when i_tvalid & i_tready.
  - i_tready=1 in S_HDR0, S_HDR1, S_CMD, S_LEN, S_DATA and S_SUM.
  - i_tready=0 in S_EMIT and S_OUT.
- State machine (transitions on an accepted byte unless stated otherwise):
  - S_HDR0: byte==HDR0 -> S_HDR1; otherwise stay.
  - S_HDR1: byte==HDR1 -> S_CMD; byte==HDR0 -> stay in S_HDR1 (resync); otherwise -> S_HDR0.
  - S_CMD: latch CMD; sum<=CMD; -> S_LEN.
  - S_LEN:
    - LEN>MAX_LEN -> S_HDR0, err_len+1.
    - LEN==0 -> S_SUM.
    - otherwise -> S_DATA.
    - In all cases latch LEN and sum<=sum+LEN.
  - S_DATA: write byte to buffer[idx]; idx+1; sum+=byte; when idx reaches LEN-1 -> S_SUM.
  - S_SUM:
    - byte==sum[7:0] -> S_EMIT.
    - otherwise -> S_HDR0 with err_sum+1. o_cmd/o_len are not updated and no output is produced.
  - S_EMIT (1 cycle): o_cmd_valid=1 and o_cmd/o_len update to the new frame. Then LEN==0 -> S_HDR0; otherwise -> S_OUT.
  - S_OUT: stream buffer[0..LEN-1]. o_tlast=1 on beat LEN-1. After that beat is accepted -> S_HDR0.
- Checksum: 8-bit modulo-256 sum of CMD, LEN and all payload bytes; header bytes and SUM are excluded.
- Latency: o_cmd_valid is asserted in the cycle after the SUM byte is accepted; the first o_tvalid is asserted in the following cycle.
- Output handshake: standard AXI-Stream. o_tdata and o_tlast are held while o_tvalid & ~o_tready. There is no bubble between beats when o_tready is held high.
- Timeout:
  - The timer clears on every accepted byte and counts in S_HDR1, S_CMD, S_LEN, S_DATA and S_SUM.
  - When the timer reaches TIMEOUT_CYCLES -> S_HDR0, err_tmo+1; the partial frame is discarded.
  - The timer is inactive in S_HDR0, S_EMIT and S_OUT.
- Counters saturate at 16'hFFFF.
- Simultaneous events: if a timeout fires in the same cycle a byte is accepted, the byte wins and the timer clears.

Optional Feature:
- Macro: UART_FRAME_PARSER_STAT_EN.
- Defined: o_err_sum, o_err_len and o_err_tmo are live saturating counters as described above.
- Undefined: the counter registers are not built; the three ports are tied to 16'd0. All other behaviour is identical.

Test Plan:
- Good frame: send AA 55 10 02 01 02 15 with o_tready=1 -> o_cmd_valid pulse with o_cmd=0x10, o_len=2; beats 0x01, then 0x02 with o_tlast=1; counters remain 0.
- Bad checksum: send AA 55 10 02 01 02 16 -> no o_cmd_valid and no beats; o_err_sum=1; an immediately following good frame is parsed correctly.
- Zero length and resync: send AA AA 55 20 00 20 -> o_cmd_valid with o_cmd=0x20, o_len=0; no o_tvalid.
- Length error: send AA 55 30 28 ... with LEN=40 > MAX_LEN=32 -> frame dropped, o_err_len=1; the parser is back in header hunt.
- Timeout: send AA 55 10 then idle 50000 cycles -> o_err_tmo=1; a subsequent complete good frame is parsed.
- Back-pressure: good frame with LEN=3 while o_tready toggles 1,0,0,1 -> beats are held stable, no loss or duplication, i_tready=0 until after the tlast handshake; reset asserted mid-S_OUT -> outputs return to their reset values immediately.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Hunts for AA 55 CMD LEN PAYLOAD SUM frames in a UART byte stream; releases only checksum-clean
// frames as a command strobe plus a tlast-delimited payload packet. Error counters: UART_FRAME_PARSER_STAT_EN.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  HDR0           = 8'hAA,
  parameter logic [7:0]  HDR1           = 8'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tvalid,
  output logic        i_tready,
  input  logic [7:0]  i_tdata,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic [7:0]  o_len,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [7:0]  o_tdata,
  output logic        o_tlast,
  output logic [15:0] o_err_sum,
  output logic [15:0] o_err_len,
  output logic [15:0] o_err_tmo
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StHdr0, StHdr1, StCmd, StLen, StData, StSum, StEmit, StOut
  } state_t;

  state_t          r_state;
  logic [7:0]      r_cmd;
  logic [7:0]      r_len;
  logic [7:0]      r_sum;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_buf [MAX_LEN];
  logic            r_cmd_valid;
  logic [7:0]      r_cmd_out;
  logic [7:0]      r_len_out;
  logic            r_tvalid;
  logic [7:0]      r_tdata;
  logic            r_tlast;

  logic            w_in_ready;
  logic            w_acc;
  logic            w_idx_last;
  logic            w_tmo;

  assign w_in_ready = (r_state != StEmit) && (r_state != StOut);
  assign w_acc      = i_tvalid && w_in_ready;
  assign w_idx_last = (8'(r_idx) == r_len - 8'd1);
  assign w_tmo      = (r_timer == TW'(TIMEOUT_CYCLES - 1));

`ifdef UART_FRAME_PARSER_STAT_EN
  logic [15:0] r_err_sum;
  logic [15:0] r_err_len;
  logic [15:0] r_err_tmo;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign o_err_sum = r_err_sum;
  assign o_err_len = r_err_len;
  assign o_err_tmo = r_err_tmo;
`else
  assign o_err_sum = 16'd0;
  assign o_err_len = 16'd0;
  assign o_err_tmo = 16'd0;
`endif

  // Payload store has no reset: contents are only read after being written for the current frame.
  always_ff @(posedge clk) begin
    if (w_acc && (r_state == StData)) r_buf[r_idx] <= i_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StHdr0;
      r_cmd       <= '0;
      r_len       <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_out   <= '0;
      r_len_out   <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
`ifdef UART_FRAME_PARSER_STAT_EN
      r_err_sum   <= '0;
      r_err_len   <= '0;
      r_err_tmo   <= '0;
`endif
    end else begin
      r_cmd_valid <= 1'b0;
      case (r_state)
        StEmit: begin
          if (r_len == 8'd0) begin
            r_state <= StHdr0;
          end else begin
            r_state  <= StOut;
            r_tvalid <= 1'b1;
            r_tdata  <= r_buf[0];
            r_tlast  <= (r_len == 8'd1);
            r_idx    <= IW'(1);
          end
        end
        StOut: begin
          if (o_tready) begin
            if (r_tlast) begin
              r_state  <= StHdr0;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
            end else begin
              r_tdata <= r_buf[r_idx];
              r_tlast <= (8'(r_idx) == r_len - 8'd1);
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          // An accepted byte always wins over a timeout in the same cycle.
          if (w_acc) begin
            r_timer <= '0;
            case (r_state)
              StHdr0: if (i_tdata == HDR0) r_state <= StHdr1;
              StHdr1: begin
                if (i_tdata == HDR1)      r_state <= StCmd;
                else if (i_tdata != HDR0) r_state <= StHdr0;
              end
              StCmd: begin
                r_cmd   <= i_tdata;
                r_sum   <= i_tdata;
                r_state <= StLen;
              end
              StLen: begin
                r_len <= i_tdata;
                r_sum <= r_sum + i_tdata;
                r_idx <= '0;
                if (i_tdata > 8'(MAX_LEN)) begin
                  r_state <= StHdr0;
`ifdef UART_FRAME_PARSER_STAT_EN
                  r_err_len <= sat_inc(r_err_len);
`endif
                end else if (i_tdata == 8'd0) begin
                  r_state <= StSum;
                end else begin
                  r_state <= StData;
                end
              end
              StData: begin
                r_sum <= r_sum + i_tdata;
                if (w_idx_last) r_state <= StSum;
                else            r_idx   <= r_idx + 1'b1;
              end
              StSum: begin
                if (i_tdata == r_sum) begin
                  r_state     <= StEmit;
                  r_cmd_valid <= 1'b1;
                  r_cmd_out   <= r_cmd;
                  r_len_out   <= r_len;
                end else begin
                  r_state <= StHdr0;
`ifdef UART_FRAME_PARSER_STAT_EN
                  r_err_sum <= sat_inc(r_err_sum);
`endif
                end
              end
              default: ;
            endcase
          end else if (r_state != StHdr0) begin
            if (w_tmo) begin
              r_state <= StHdr0;
              r_timer <= '0;
`ifdef UART_FRAME_PARSER_STAT_EN
              r_err_tmo <= sat_inc(r_err_tmo);
`endif
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign i_tready    = w_in_ready;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd       = r_cmd_out;
  assign o_len       = r_len_out;
  assign o_tvalid    = r_tvalid;
  assign o_tdata     = r_tdata;
  assign o_tlast     = r_tlast;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: vector table, hand-written corner sequences and
// randomized frames scored against expectations derived from how each frame was built.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 32;
  localparam int TMO     = 50000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [7:0]  i_tdata = 8'h00;
  logic        o_cmd_valid;
  logic [7:0]  o_cmd;
  logic [7:0]  o_len;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic [15:0] o_err_sum;
  logic [15:0] o_err_len;
  logic [15:0] o_err_tmo;

  uart_frame_parser #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tvalid    (i_tvalid),
    .i_tready    (i_tready),
    .i_tdata     (i_tdata),
    .o_cmd_valid (o_cmd_valid),
    .o_cmd       (o_cmd),
    .o_len       (o_len),
    .o_tvalid    (o_tvalid),
    .o_tready    (o_tready),
    .o_tdata     (o_tdata),
    .o_tlast     (o_tlast),
    .o_err_sum   (o_err_sum),
    .o_err_len   (o_err_len),
    .o_err_tmo   (o_err_tmo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int bp_mode = 0;  // 0: ready held high, 1: random ready, 2: driven by the sequence
  int exp_sum = 0;
  int exp_lenerr = 0;
  int exp_tmo = 0;

  logic [15:0] obs_cmd[$];
  logic [8:0]  obs_beat[$];
  logic [7:0]  exp_pay[$];
  logic [7:0]  tx[$];

  logic        in_out = 1'b0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_beat = '0;
  logic [15:0] last_cl = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int c);
`ifdef UART_FRAME_PARSER_STAT_EN
    return (c > 65535) ? 16'hFFFF : 16'(c);
`else
    return 16'(c) & 16'h0000;
`endif
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_err_sum"}, o_err_sum, cnt_exp(exp_sum));
    check({tag, "_err_len"}, o_err_len, cnt_exp(exp_lenerr));
    check({tag, "_err_tmo"}, o_err_tmo, cnt_exp(exp_tmo));
  endtask

  // Output monitor: collects strobes and handshaken beats, checks hold and input stall rules.
  always @(negedge clk) begin
    if (rst) begin
      in_out     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_tvalid", o_tvalid, 1);
        check("hold_beat", {o_tlast, o_tdata}, prev_beat);
      end
      if (in_out) begin
        check("in_ready_low_out", i_tready, 0);
        check("cmd_len_stable", {o_cmd, o_len}, last_cl);
      end
      if (o_cmd_valid) begin
        check("in_ready_low_emit", i_tready, 0);
        obs_cmd.push_back({o_cmd, o_len});
        last_cl = {o_cmd, o_len};
        in_out  = (o_len != 8'd0);
      end
      if (o_tvalid && o_tready) begin
        obs_beat.push_back({o_tlast, o_tdata});
        if (o_tlast) in_out = 1'b0;
      end
      prev_stall = o_tvalid && !o_tready;
      prev_beat  = {o_tlast, o_tdata};
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_mode == 0)      o_tready = 1'b1;
    else if (bp_mode == 1) o_tready = 1'($urandom_range(0, 1));
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int  k;
    bit  done;
    i_tvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    i_tvalid = 1'b1;
    i_tdata  = b;
    k = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      k++;
      if (i_tready || k > 2000) done = 1'b1;
    end
    if (!i_tready) check("in_accept_timeout", 0, 1);
    @(posedge clk); #1;
    i_tvalid = 1'b0;
  endtask

  task automatic send_tx(input int maxgap);
    foreach (tx[i]) send_byte(tx[i], $urandom_range(0, maxgap));
  endtask

  task automatic drain();
    int k;
    bit done;
    repeat (3) @(posedge clk);
    k = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      k++;
      if ((i_tready && !o_tvalid && !o_cmd_valid) || k > 3000) done = 1'b1;
    end
    if (k > 3000) check("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input bit ok, input logic [7:0] cmd,
                             input logic [7:0] len);
    int nb;
    nb = ok ? int'(len) : 0;
    check({tag, "_cmd_valid_cnt"}, obs_cmd.size(), ok ? 1 : 0);
    if (ok && obs_cmd.size() > 0) begin
      check({tag, "_cmd"}, obs_cmd[0][15:8], cmd);
      check({tag, "_len"}, obs_cmd[0][7:0], len);
    end
    check({tag, "_beat_cnt"}, obs_beat.size(), nb);
    for (int i = 0; i < nb && i < obs_beat.size(); i++) begin
      check({tag, "_beat_data"}, obs_beat[i][7:0], exp_pay[i]);
      check({tag, "_beat_last"}, obs_beat[i][8], (i == nb - 1) ? 1 : 0);
    end
    check_counters(tag);
    obs_cmd.delete();
    obs_beat.delete();
  endtask

  // Builds a well-formed frame into tx/exp_pay; checksum is plain modulo-256 arithmetic.
  task automatic build_frame(input logic [7:0] cmd, input int len, input bit bad_sum);
    int s;
    logic [7:0] b;
    tx.delete();
    exp_pay.delete();
    tx.push_back(8'hAA);
    tx.push_back(8'h55);
    tx.push_back(cmd);
    tx.push_back(8'(len));
    s = int'(cmd) + len;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      tx.push_back(b);
      exp_pay.push_back(b);
      s += int'(b);
    end
    s = s % 256;
    if (bad_sum) s = (s + 1 + $urandom_range(0, 254)) % 256;
    tx.push_back(8'(s));
  endtask

  typedef struct {
    int         n;
    logic [7:0] b [12];
    bit         ok;
    logic [7:0] cmd;
    logic [7:0] len;
    int         poff;
    int         dsum;
    int         dlen;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{7, '{8'hAA, 8'h55, 8'h10, 8'h02, 8'h01, 8'h02, 8'h15, 0, 0, 0, 0, 0},
                1, 8'h10, 8'h02, 4, 0, 0};
    vecs[1] = '{7, '{8'hAA, 8'h55, 8'h10, 8'h02, 8'h01, 8'h02, 8'h16, 0, 0, 0, 0, 0},
                0, 8'h00, 8'h00, 0, 1, 0};
    vecs[2] = '{6, '{8'hAA, 8'h55, 8'hFF, 8'h01, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0},
                1, 8'hFF, 8'h01, 4, 0, 0};
    vecs[3] = '{6, '{8'hAA, 8'hAA, 8'h55, 8'h20, 8'h00, 8'h20, 0, 0, 0, 0, 0, 0},
                1, 8'h20, 8'h00, 0, 0, 0};
    vecs[4] = '{4, '{8'hAA, 8'h55, 8'h30, 8'h28, 0, 0, 0, 0, 0, 0, 0, 0},
                0, 8'h00, 8'h00, 0, 0, 1};
    vecs[5] = '{10, '{8'h00, 8'h13, 8'hAA, 8'h12, 8'hAA, 8'h55, 8'h05, 8'h01, 8'h77, 8'h7D, 0, 0},
                1, 8'h05, 8'h01, 8, 0, 0};
    vecs[6] = '{4, '{8'hAA, 8'h55, 8'h01, 8'h21, 0, 0, 0, 0, 0, 0, 0, 0},
                0, 8'h00, 8'h00, 0, 0, 1};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_tready", i_tready, 1);
    check("rst_cmd_valid", o_cmd_valid, 0);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_cmd", o_cmd, 0);
    check("rst_len", o_len, 0);
    check_counters("rst");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Vector table.
    foreach (vecs[i]) begin
      tx.delete();
      for (int j = 0; j < vecs[i].n; j++) tx.push_back(vecs[i].b[j]);
      send_tx(0);
      drain();
      exp_sum    += vecs[i].dsum;
      exp_lenerr += vecs[i].dlen;
      exp_pay.delete();
      for (int j = 0; j < int'(vecs[i].len); j++) exp_pay.push_back(vecs[i].b[vecs[i].poff + j]);
      check_frame($sformatf("vec%0d", i), vecs[i].ok, vecs[i].cmd, vecs[i].len);
    end

    // Largest legal payload.
    build_frame(8'h42, MAX_LEN, 1'b0);
    send_tx(1);
    drain();
    check_frame("max_len", 1'b1, 8'h42, 8'(MAX_LEN));

    // Back-pressure: ready 1,0,0,1 across the first beats.
    bp_mode  = 2;
    o_tready = 1'b1;
    tx.delete();
    tx = '{8'hAA, 8'h55, 8'h07, 8'h03, 8'h11, 8'h22, 8'h33, 8'h70};
    exp_pay = '{8'h11, 8'h22, 8'h33};
    send_tx(0);
    begin
      int k = 0;
      while (!o_tvalid && k < 20) begin @(negedge clk); k++; end
    end
    check("bp_first_tvalid", o_tvalid, 1);
    @(posedge clk); #1; o_tready = 1'b0;
    @(posedge clk); #1; o_tready = 1'b0;
    @(posedge clk); #1; o_tready = 1'b1;
    drain();
    check_frame("backpressure", 1'b1, 8'h07, 8'h03);

    // Reset while the payload is stalled.
    o_tready = 1'b0;
    send_tx(0);
    begin
      int k = 0;
      while (!o_tvalid && k < 20) begin @(negedge clk); k++; end
    end
    check("mid_rst_tvalid_before", o_tvalid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", o_tvalid, 0);
    check("mid_rst_tlast", o_tlast, 0);
    check("mid_rst_tdata", o_tdata, 0);
    check("mid_rst_cmd", o_cmd, 0);
    check("mid_rst_len", o_len, 0);
    check("mid_rst_i_tready", i_tready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    o_tready = 1'b1;
    bp_mode = 0;
    obs_cmd.delete();
    obs_beat.delete();
    exp_sum = 0;
    exp_lenerr = 0;
    exp_tmo = 0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_cmd", obs_cmd.size(), 0);
    check("post_rst_no_beats", obs_beat.size(), 0);
    check_counters("post_rst");

    // Timeout mid-frame, then a good frame.
    tx = '{8'hAA, 8'h55, 8'h10};
    send_tx(0);
    repeat (TMO + 5) @(posedge clk);
    #1;
    exp_tmo++;
    check_frame("timeout", 1'b0, 8'h00, 8'h00);
    tx = '{8'hAA, 8'h55, 8'h10, 8'h02, 8'h01, 8'h02, 8'h15};
    exp_pay = '{8'h01, 8'h02};
    send_tx(0);
    drain();
    check_frame("after_timeout", 1'b1, 8'h10, 8'h02);

    // Randomized frames with noise, gaps and random downstream ready.
    bp_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int kind;
      int len;
      logic [7:0] cmd;
      logic [7:0] nb;
      kind = $urandom_range(0, 9);
      cmd  = 8'($urandom_range(0, 255));
      len  = ($urandom_range(0, 4) == 0) ? MAX_LEN : $urandom_range(0, MAX_LEN);
      for (int k = 0; k < $urandom_range(0, 3); k++) begin
        nb = 8'($urandom_range(0, 254));
        if (nb == 8'hAA) nb = 8'hAB;
        send_byte(nb, $urandom_range(0, 2));
      end
      if (kind == 1) begin
        len = $urandom_range(MAX_LEN + 1, 255);
        tx.delete();
        tx = '{8'hAA, 8'h55, cmd, 8'(len)};
        exp_lenerr++;
      end else begin
        build_frame(cmd, len, kind == 0);
        if (kind == 0) exp_sum++;
      end
      send_tx(2);
      drain();
      check_frame($sformatf("rnd%0d", f), kind >= 2, cmd, 8'(len));
    end
    bp_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
